// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU definitions: funct3 codes, exception causes, FSM encoding
// and the access-fault decode used at accept time.
package lsu_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_ILLEGAL  = 2'b10
    } exc_cause_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_WR     = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Misalignment is checked first so an odd-address HU store reports
    // misaligned rather than illegal.
    function automatic exc_cause_e decode_exc(input logic       is_store,
                                              input logic [2:0] f3,
                                              input logic [1:0] a);
        logic mis;
        logic ill;
        mis = ((f3 == F3_H || f3 == F3_HU) && a[0]) ||
              (f3 == F3_W && a != 2'b00);
        if (is_store)
            ill = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        else
            ill = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        if (mis)
            return EXC_MISALIGN;
        else if (ill)
            return EXC_ILLEGAL;
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory request/ack bus between the LSU (master) and memory (slave).
interface lsu_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: sub-word store merge into a read word, and
// sub-word load extraction with sign/zero extension.
module lsu_lane
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign sel_b = mem_word[{byte_off, 3'b000} +: 8];
    assign sel_h = byte_off[1] ? mem_word[31:16] : mem_word[15:0];

    // Store merge: overwrite only the addressed lanes of the fetched word
    always_comb begin
        merged_word = mem_word;
        case (funct3)
            F3_B: merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
            F3_H: begin
                if (byte_off[1])
                    merged_word[31:16] = store_data[15:0];
                else
                    merged_word[15:0]  = store_data[15:0];
            end
            F3_W:    merged_word = store_data;
            default: merged_word = mem_word;
        endcase
    end

    // Load extract: pick the addressed lane, then extend
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{sel_b[7]}}, sel_b};
            F3_H:    load_data = {{16{sel_h[15]}}, sel_h};
            F3_W:    load_data = mem_word;
            F3_BU:   load_data = {24'h0, sel_b};
            F3_HU:   load_data = {16'h0, sel_h};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one MEM-stage op at a time, stalls
// the pipe, runs word reads/writes (read-modify-write for SB/SH) against
// a variable-latency memory, and pulses a one-cycle completion.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int DMEM_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] load_result,
    output logic        exc,
    output logic [1:0]  exc_cause,
    lsu_ctrl_if.master  dmem
);

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] sdata_q, sdata_d;
    exc_cause_e  cause_q, cause_d;
    logic [31:0] ld_q, ld_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;

    logic        accept;
    exc_cause_e  dec_cause;
    logic [31:0] lane_merge;
    logic [31:0] lane_load;
    logic        unused_addr_hi;

    // Address bits above the memory window are intentionally dropped
    assign unused_addr_hi = ^addr[31:DMEM_AW];

    assign accept    = (state_q == ST_IDLE) && ex_valid && (ex_load || ex_store);
    assign dec_cause = decode_exc(ex_store, funct3, addr[1:0]);

    lsu_lane u_lane (
        .funct3      (funct3_q),
        .byte_off    (off_q),
        .store_data  (sdata_q),
        .mem_word    (dmem.dmem_rdata),
        .merged_word (lane_merge),
        .load_data   (lane_load)
    );

    // State register; reset wins over any in-flight request
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: decode on accept, advance each memory beat on ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_cause != EXC_NONE)
                        state_d = ST_DONE;
                    else if (ex_load)
                        state_d = ST_RD;
                    else if (funct3 == F3_W)
                        state_d = ST_WR;
                    else
                        state_d = ST_RMW_RD;
                end
            end
            ST_RD:     if (dmem.dmem_ack) state_d = ST_DONE;
            ST_RMW_RD: if (dmem.dmem_ack) state_d = ST_RMW_WR;
            ST_RMW_WR: if (dmem.dmem_ack) state_d = ST_DONE;
            ST_WR:     if (dmem.dmem_ack) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pipeline-facing outputs, decoded from the current state
    always_comb begin
        stall        = 1'b0;
        result_valid = 1'b0;
        exc          = 1'b0;
        exc_cause    = EXC_NONE;
        load_result  = '0;
        case (state_q)
            ST_IDLE: stall = accept && !rst;
            ST_RD, ST_RMW_RD, ST_RMW_WR, ST_WR: stall = 1'b1;
            ST_DONE: begin
                result_valid = 1'b1;
                exc          = (cause_q != EXC_NONE);
                exc_cause    = cause_q;
                load_result  = ld_q;
            end
            default: stall = 1'b0;
        endcase
    end

    // Datapath next values: latch op on accept, capture read data on ack
    always_comb begin
        funct3_d     = funct3_q;
        off_d        = off_q;
        sdata_d      = sdata_q;
        cause_d      = cause_q;
        ld_d         = ld_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        if (accept) begin
            funct3_d     = funct3;
            off_d        = addr[1:0];
            sdata_d      = store_data;
            cause_d      = dec_cause;
            ld_d         = '0;
            dmem_addr_d  = {{(32-DMEM_AW){1'b0}}, addr[DMEM_AW-1:2], 2'b00};
            dmem_wdata_d = ex_store ? store_data : '0;
        end
        if (state_q == ST_RD && dmem.dmem_ack)
            ld_d = lane_load;
        if (state_q == ST_RMW_RD && dmem.dmem_ack)
            dmem_wdata_d = lane_merge;
        dmem_req_d = (state_d == ST_RD) || (state_d == ST_RMW_RD) ||
                     (state_d == ST_RMW_WR) || (state_d == ST_WR);
        dmem_we_d  = (state_d == ST_RMW_WR) || (state_d == ST_WR);
    end

    // Datapath and memory-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q     <= '0;
            off_q        <= '0;
            sdata_q      <= '0;
            cause_q      <= EXC_NONE;
            ld_q         <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            sdata_q      <= sdata_d;
            cause_q      <= cause_d;
            ld_q         <= ld_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign dmem.dmem_req   = dmem_req_q;
    assign dmem.dmem_we    = dmem_we_q;
    assign dmem.dmem_addr  = dmem_addr_q;
    assign dmem.dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small word memory and programmable ack delay.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_valid, ex_load, ex_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, result_valid, exc;
    logic [31:0] load_result;
    logic [1:0]  exc_cause;

    lsu_ctrl_if dif();

    lsu_ctrl #(.DMEM_AW(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_load      (ex_load),
        .ex_store     (ex_store),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .result_valid (result_valid),
        .load_result  (load_result),
        .exc          (exc),
        .exc_cause    (exc_cause),
        .dmem         (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model
    logic [31:0] mem [0:255];
    int          ack_delay;
    int          ack_cnt;
    int          wr_cnt, rd_cnt, req_cyc;
    logic [31:0] last_wa, last_wd, last_ra;
    logic        pl_we;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;

    assign dif.dmem_ack   = dif.dmem_req && (ack_cnt == ack_delay);
    assign dif.dmem_rdata = mem[dif.dmem_addr[9:2]];

    always @(posedge clk) begin
        if (rst || !dif.dmem_req || dif.dmem_ack) ack_cnt <= 0;
        else ack_cnt <= ack_cnt + 1;
        if (dif.dmem_req) req_cyc <= req_cyc + 1;
        if (pl_we) mem[pl_idx] <= pl_val;
        else if (dif.dmem_req && dif.dmem_ack) begin
            if (dif.dmem_we) begin
                mem[dif.dmem_addr[9:2]] <= dif.dmem_wdata;
                wr_cnt  <= wr_cnt + 1;
                last_wa <= dif.dmem_addr;
                last_wd <= dif.dmem_wdata;
            end else begin
                rd_cnt  <= rd_cnt + 1;
                last_ra <= dif.dmem_addr;
            end
        end
    end

    int n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Issue one op; accept cycle counts as cycle 1.
    task automatic run_op(input string tag, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                          input int dly, input int exp_cyc, input logic exp_exc,
                          input logic [1:0] exp_cause, input logic [31:0] exp_res);
        int   cyc;
        int   rq0;
        logic done;
        ack_delay = dly;
        rq0 = req_cyc;
        @(negedge clk);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; funct3 = f3; addr = a; store_data = sd;
        #1 chk({tag, "_acc_stall"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1 ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        cyc = 1; done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (result_valid) done = 1'b1;
            else chk({tag, "_busy_stall"}, 32'(stall), 32'd1);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_exc"}, 32'(exc), 32'(exp_exc));
        chk({tag, "_cause"}, 32'(exc_cause), 32'(exp_cause));
        chk({tag, "_res"}, load_result, exp_res);
        chk({tag, "_done_stall"}, 32'(stall), 32'd0);
        if (exp_exc) chk({tag, "_noreq"}, 32'(req_cyc - rq0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int w0, r0;

    initial begin
        n_chk = 0; n_fail = 0;
        ack_delay = 0; wr_cnt = 0; rd_cnt = 0; req_cyc = 0;
        last_wa = '0; last_wd = '0; last_ra = '0;
        pl_we = 1'b0; pl_idx = '0; pl_val = '0;
        rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        funct3 = '0; addr = '0; store_data = '0;

        preload(8'h04, 32'h8899AABB);
        preload(8'h08, 32'h11223344);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_exc", {exc_cause, exc}, 32'd0);
        chk("rst_res", load_result, 32'd0);
        chk("rst_req", {dif.dmem_req, dif.dmem_we}, 32'd0);
        chk("rst_addr", dif.dmem_addr, 32'd0);
        chk("rst_wdata", dif.dmem_wdata, 32'd0);
        rst = 1'b0;

        // sub-word loads, zero-wait ack
        run_op("lb_11",  1, 0, 3'b000, 32'h11, 0, 0, 3, 0, 2'b00, 32'hFFFFFFAA);
        run_op("lbu_13", 1, 0, 3'b100, 32'h13, 0, 0, 3, 0, 2'b00, 32'h00000088);
        run_op("lh_12",  1, 0, 3'b001, 32'h12, 0, 0, 3, 0, 2'b00, 32'hFFFF8899);
        chk("lh_12_raddr", last_ra, 32'h10);

        // SH with 2-cycle ack delay per beat
        w0 = wr_cnt; r0 = rd_cnt;
        run_op("sh_22", 0, 1, 3'b001, 32'h22, 32'h0000BEEF, 2, 8, 0, 2'b00, 32'h0);
        chk("sh_22_rd", 32'(rd_cnt - r0), 32'd1);
        chk("sh_22_wr", 32'(wr_cnt - w0), 32'd1);
        chk("sh_22_raddr", last_ra, 32'h20);
        chk("sh_22_waddr", last_wa, 32'h20);
        chk("sh_22_wdata", last_wd, 32'hBEEF3344);

        // SB top lane, then read back lane 2
        run_op("sb_23", 0, 1, 3'b000, 32'h23, 32'h12345677, 0, 4, 0, 2'b00, 32'h0);
        chk("sb_23_wdata", last_wd, 32'h77EF3344);
        run_op("lb_22", 1, 0, 3'b000, 32'h22, 0, 0, 3, 0, 2'b00, 32'hFFFFFFEF);

        // exceptions
        run_op("lw_13_mis", 1, 0, 3'b010, 32'h13, 0, 0, 2, 1, 2'b01, 32'h0);
        run_op("ld_f3_011", 1, 0, 3'b011, 32'h40, 0, 0, 2, 1, 2'b10, 32'h0);
        run_op("st_f3_101_odd", 0, 1, 3'b101, 32'h41, 0, 0, 2, 1, 2'b01, 32'h0);
        run_op("st_f3_100", 0, 1, 3'b100, 32'h40, 0, 0, 2, 1, 2'b10, 32'h0);
        run_op("lh_21_mis", 1, 0, 3'b001, 32'h21, 0, 0, 2, 1, 2'b01, 32'h0);

        // back-to-back SW / LHU
        run_op("sw_30", 0, 1, 3'b010, 32'h30, 32'hCAFEBABE, 0, 3, 0, 2'b00, 32'h0);
        chk("sw_30_waddr", last_wa, 32'h30);
        chk("sw_30_wdata", last_wd, 32'hCAFEBABE);
        run_op("lhu_32", 1, 0, 3'b101, 32'h32, 0, 0, 3, 0, 2'b00, 32'h0000CAFE);
        // address bits above DMEM_AW are dropped
        run_op("lw_1030", 1, 0, 3'b010, 32'h1030, 0, 0, 3, 0, 2'b00, 32'hCAFEBABE);
        chk("lw_1030_raddr", last_ra, 32'h30);

        // reset while RMW read is waiting for ack
        w0 = wr_cnt;
        ack_delay = 5;
        @(negedge clk);
        ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b1; funct3 = 3'b000;
        addr = 32'h21; store_data = 32'h55;
        @(posedge clk);
        #1 ex_valid = 1'b0; ex_store = 1'b0;
        @(negedge clk);
        chk("rmw_req_pre", {dif.dmem_req, dif.dmem_we}, 32'b10);
        rst = 1'b1;
        @(negedge clk);
        chk("rmw_rst_req", 32'(dif.dmem_req), 32'd0);
        chk("rmw_rst_stall", 32'(stall), 32'd0);
        chk("rmw_rst_rv", 32'(result_valid), 32'd0);
        rst = 1'b0;
        ack_delay = 0;
        repeat (3) @(negedge clk);
        chk("rmw_rst_nowr", 32'(wr_cnt - w0), 32'd0);
        chk("rmw_rst_mem", mem[8'h08], 32'h77EF3344);
        chk("rmw_rst_idle", 32'(dif.dmem_req), 32'd0);

        run_op("lw_20", 1, 0, 3'b010, 32'h20, 0, 0, 3, 0, 2'b00, 32'h77EF3344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: DMEM_AW, default 10, byte-address bits forwarded to data memory; upper bits of dmem_addr are zero.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ex_valid  in  1  MEM-stage operation present this cycle.
REQ-005 ex_load  in  1  operation is a load.
REQ-006 ex_store  in  1  operation is a store; ex_load and ex_store never both high.
REQ-007 funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  in  32  byte address from ALU.
REQ-009 store_data  in  32  rs2 value, right-aligned.
REQ-010 stall  out  1  freeze upstream pipeline.
REQ-011 result_valid  out  1  one-cycle completion pulse.
REQ-012 load_result  out  32  extended load data, valid with result_valid.
REQ-013 exc  out  1  exception pulse, coincident with result_valid.
REQ-014 exc_cause  out  2  01 misaligned, 10 illegal funct3, 00 none.
REQ-015 dmem_req  out  1  memory request, registered.
REQ-016 dmem_we  out  1  request is a write.
REQ-017 dmem_addr  out  32  word-aligned address (bits [1:0] = 00).
REQ-018 dmem_wdata  out  32  full write word.
REQ-019 dmem_rdata  in  32  read word, valid when dmem_ack high.
REQ-020 dmem_ack  in  1  request completes at this posedge; arbitrary latency >= 0 cycles after dmem_req rises.

Function
REQ-021 FSM states: IDLE, RD, RMW_RD, RMW_WR, WR, DONE.
REQ-022 IDLE, ex_valid & (ex_load|ex_store): decode; LW->RD, SW->WR, SB/SH->RMW_RD, misaligned or illegal funct3->DONE with exc set; addr, funct3, store_data latched.
REQ-023 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=00; store funct3 other than 000/001/010 and load funct3 011/110/111 are illegal; misaligned takes priority over illegal; no memory request issued.
REQ-024 stall = 1 combinationally in the accepting IDLE cycle and in RD, RMW_RD, RMW_WR, WR; 0 in IDLE otherwise and in DONE.
REQ-025 dmem_req = 1 exactly in RD, RMW_RD, RMW_WR, WR; dmem_we = 1 only in RMW_WR, WR; dmem_addr = {latched addr[31:2],00}, stable while dmem_req held.
REQ-026 dmem_req stays asserted until dmem_ack sampled high; ack outside a request state is ignored.
REQ-027 RD + ack: capture rdata -> DONE.  WR + ack -> DONE.  RMW_RD + ack: capture word -> RMW_WR.  RMW_WR + ack -> DONE.
REQ-028 RMW merge: SB replaces byte lane addr[1:0]; SH replaces lanes 1:0 (addr[1]=0) or 3:2 (addr[1]=1); other lanes from captured word.
REQ-029 Load extract: lane selected by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W unmodified.
REQ-030 DONE lasts one cycle: result_valid=1, load_result valid (0 for stores and exceptions), then IDLE; new op may be accepted in the following IDLE cycle.
REQ-031 Minimum latency with zero-wait ack: LW/SW 3 cycles accept-to-result_valid, SB/SH 4, exception 2.

Reset
REQ-032 rst forces IDLE at next posedge, overriding any state, including mid-request; an outstanding ack is dropped.
REQ-033 Reset values: stall 0, result_valid 0, exc 0, exc_cause 00, load_result 0, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0.

Structure
REQ-034 Shared package holds funct3 codes, exc_cause codes, FSM state encoding.
REQ-035 One sub-module, lsu_lane, combinational: byte-lane merge (REQ-028) and load extract (REQ-029).

Verification
REQ-036 mem[0x10]=0x8899AABB, LB addr 0x11, ack same cycle -> load_result 0xFFFFFFAA, result_valid 3 cycles after accept.
REQ-037 mem[0x20]=0x11223344, SH 0xBEEF at 0x22, ack delayed 2 cycles each -> read then write of 0xBEEF3344 at 0x20, stall high throughout.
REQ-038 LW at 0x13 -> exc=1, cause 01, no dmem_req, load_result 0, result_valid 2 cycles after accept.
REQ-039 Load funct3 011 at 0x40 -> exc=1, cause 10, no dmem_req.
REQ-040 rst asserted while RMW_RD awaits ack -> next cycle IDLE, dmem_req 0, stall 0, memory word unchanged.
REQ-041 Back-to-back SW 0xCAFEBABE at 0x30 then LHU 0x32 -> load_result 0x0000CAFE.
